// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-memory boot loader.
package mips_pkg;

  localparam int unsigned IM_WORD_W = 32;
  localparam int unsigned IM_ADDR_W = 10;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned HDR_W     = 16;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_HDR_HI = 3'd1,
    LD_HDR_LO = 3'd2,
    LD_DATA   = 3'd3,
    LD_CHK    = 3'd4,
    LD_DONE   = 3'd5,
    LD_ERR    = 3'd6
  } ld_state_e;

endpackage

// File: rtl/im_word_packer.sv
// Assembles four MSB-first bytes into one 32-bit word and emits a one-cycle write strobe.
module im_word_packer
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [BYTE_W-1:0]    byte_i,
  output logic                 last_c_o,
  output logic                 we_o,
  output logic [IM_WORD_W-1:0] word_o
);

  localparam int unsigned CNT_W   = 2;
  localparam int unsigned SHIFT_W = IM_WORD_W - BYTE_W;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [IM_WORD_W-1:0] word_q, word_d;
  logic                 we_q, we_d;

  // Next byte accepted completes the current word.
  assign last_c_o = (cnt_q == CNT_W'(3));
  assign we_o     = we_q;
  assign word_o   = word_q;

  // Byte counting and shifting; the fourth byte publishes the word.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    we_d    = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], byte_i};
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(3)) begin
        word_d = {shift_q, byte_i};
        we_d   = 1'b1;
      end
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: rtl/im_boot_loader.sv
// Byte-stream boot loader for the MIPS instruction memory; holds the core in reset
// until a framed image (N_HI, N_LO, N words MSB first) has been written.
// Optional trailing XOR checksum byte enabled by IM_LOADER_CHECKSUM_EN.
module im_boot_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = IM_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 byte_valid,
  input  logic [BYTE_W-1:0]    byte_data,
  output logic                 byte_ready,
  output logic                 im_we,
  output logic [ADDR_W-1:0]    im_addr,
  output logic [IM_WORD_W-1:0] im_wdata,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 err,
  output logic [HDR_W-1:0]     word_count
);

  localparam int unsigned IM_DEPTH = 32'(1) << ADDR_W;

  ld_state_e          state_q, state_d;
  logic               byte_ready_q, byte_ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic [HDR_W-1:0]   word_count_q, word_count_d;
  logic [BYTE_W-1:0]  hdr_hi_q, hdr_hi_d;
  logic [HDR_W-1:0]   words_done_q, words_done_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]  csum_q, csum_d;
`endif

  logic               xfer;
  logic               pk_clr, pk_en, pk_last_c;
  logic [HDR_W-1:0]   hdr_n;

  assign xfer   = byte_valid & byte_ready_q;
  assign hdr_n  = {hdr_hi_q, byte_data};
  assign pk_en  = xfer & (state_q == LD_DATA);
  assign pk_clr = start & ((state_q == LD_IDLE) | (state_q == LD_DONE) | (state_q == LD_ERR));

  im_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (pk_clr),
    .en_i     (pk_en),
    .byte_i   (byte_data),
    .last_c_o (pk_last_c),
    .we_o     (im_we),
    .word_o   (im_wdata)
  );

  // Loader FSM: header decode, word/address tracking, completion status.
  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    err_d        = err_q;
    cpu_rst_d    = cpu_rst_q;
    word_count_d = word_count_q;
    hdr_hi_d     = hdr_hi_q;
    words_done_d = words_done_q;
    addr_d       = addr_q;
`ifdef IM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    unique case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_d      = LD_HDR_HI;
          done_d       = 1'b0;
          err_d        = 1'b0;
          cpu_rst_d    = 1'b1;
          words_done_d = '0;
`ifdef IM_LOADER_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end
      LD_HDR_HI: begin
        if (xfer) begin
          hdr_hi_d = byte_data;
          state_d  = LD_HDR_LO;
        end
      end
      LD_HDR_LO: begin
        if (xfer) begin
          word_count_d = hdr_n;
          if (32'(hdr_n) > IM_DEPTH) begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end else if (hdr_n == '0) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_d = LD_CHK;
`else
            state_d   = LD_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
`endif
          end else begin
            state_d = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (xfer) begin
`ifdef IM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data;
`endif
          if (pk_last_c) begin
            addr_d       = ADDR_W'(words_done_q);
            words_done_d = words_done_q + HDR_W'(1);
            if (words_done_q + HDR_W'(1) == word_count_q) begin
`ifdef IM_LOADER_CHECKSUM_EN
              state_d = LD_CHK;
`else
              state_d   = LD_DONE;
              done_d    = 1'b1;
              cpu_rst_d = 1'b0;
`endif
            end
          end
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      LD_CHK: begin
        if (xfer) begin
          if (byte_data == csum_q) begin
            state_d   = LD_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = LD_IDLE;
    endcase
    byte_ready_d = (state_d == LD_HDR_HI) || (state_d == LD_HDR_LO) ||
                   (state_d == LD_DATA)   || (state_d == LD_CHK);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LD_IDLE;
    else      state_q <= state_d;
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_ready_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_rst_q    <= 1'b1;
      word_count_q <= '0;
      hdr_hi_q     <= '0;
      words_done_q <= '0;
      addr_q       <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      byte_ready_q <= byte_ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cpu_rst_q    <= cpu_rst_d;
      word_count_q <= word_count_d;
      hdr_hi_q     <= hdr_hi_d;
      words_done_q <= words_done_d;
      addr_q       <= addr_d;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign im_addr    = addr_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// Self-checking bench for im_boot_loader (scoreboard of expected IM writes).
module tb_im_boot_loader;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;
  logic [15:0]   word_count;

  im_boot_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [31:0] frame_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Capture every write strobe seen on the IM port.
  always @(negedge clk) begin
    if (rst && im_we) obs_q.push_back({im_addr, im_wdata});
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!byte_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_byte timeout: byte_ready=%b, required 1 within 200 cycles", byte_ready);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Sends frame_q as a framed image; expected writes go to the scoreboard.
  task automatic send_frame(input int gap, input logic [7:0] csum_flip);
    logic [15:0] n;
    logic [7:0]  cs;
    cs = 8'h00;
    n  = 16'(frame_q.size());
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      exp_q.push_back({AW'(i), frame_q[i]});
      for (int k = 3; k >= 0; k--) begin
        logic [7:0] b;
        b  = frame_q[i][k*8 +: 8];
        cs = cs ^ b;
        send_byte(b, gap);
      end
    end
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(cs ^ csum_flip, gap);
`else
    if (csum_flip != 8'h00 && cs == 8'h00) $display("note: checksum flip ignored");
`endif
  endtask

  task automatic wait_end(input string name);
    int t;
    t = 0;
    while (!(done || err) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (!(done || err)) begin
      n_err++;
      $display("FAIL %s end timeout: done=%b err=%b, required one of them within 50 cycles", name, done, err);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 0) begin
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
      end else begin
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h20, 0); send_byte(8'h08, 0);
        #2 rst = 1'b0;
        #1;
      end
      n_cmp += 8;
      if (byte_ready !== 1'b0) begin n_err++; $display("FAIL reset%0d byte_ready got %b want 0", ph, byte_ready); end
      if (im_we !== 1'b0) begin n_err++; $display("FAIL reset%0d im_we got %b want 0", ph, im_we); end
      if (im_addr !== '0) begin n_err++; $display("FAIL reset%0d im_addr got %h want 0", ph, im_addr); end
      if (im_wdata !== 32'h0) begin n_err++; $display("FAIL reset%0d im_wdata got %h want 0", ph, im_wdata); end
      if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL reset%0d cpu_rst got %b want 1", ph, cpu_rst); end
      if (done !== 1'b0) begin n_err++; $display("FAIL reset%0d done got %b want 0", ph, done); end
      if (err !== 1'b0) begin n_err++; $display("FAIL reset%0d err got %b want 0", ph, err); end
      if (word_count !== 16'h0) begin n_err++; $display("FAIL reset%0d word_count got %h want 0", ph, word_count); end
      n_cmp++;
      if (obs_q.size() != 0) begin n_err++; $display("FAIL reset%0d writes got %0d want 0", ph, obs_q.size()); end
      obs_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_with_byte();
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'hAB;
    @(posedge clk); #1;
    start = 1'b0; byte_valid = 1'b0;
    frame_q = '{32'hDEADBEEF};
    send_frame(0, 8'h00);
    wait_end("start_byte");
    n_cmp += 2;
    if (done !== 1'b1) begin n_err++; $display("FAIL start_byte done got %b want 1", done); end
    if (word_count !== 16'd1) begin n_err++; $display("FAIL start_byte word_count got %0d want 1", word_count); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL start_byte write count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL start_byte write got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_basic(input int gap, input string name);
    pulse_start();
    n_cmp += 2;
    if (done !== 1'b0) begin n_err++; $display("FAIL %s done after start got %b want 0", name, done); end
    if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL %s cpu_rst after start got %b want 1", name, cpu_rst); end
    frame_q = '{32'h20080005, 32'h00084820};
    send_frame(gap, 8'h00);
    wait_end(name);
    n_cmp += 4;
    if (done !== 1'b1) begin n_err++; $display("FAIL %s done got %b want 1", name, done); end
    if (err !== 1'b0) begin n_err++; $display("FAIL %s err got %b want 0", name, err); end
    if (cpu_rst !== 1'b0) begin n_err++; $display("FAIL %s cpu_rst got %b want 0", name, cpu_rst); end
    if (word_count !== 16'd2) begin n_err++; $display("FAIL %s word_count got %0d want 2", name, word_count); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL %s write count got %0d want %0d", name, obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL %s write got %h:%h want %h:%h", name, o.addr, o.data, e.addr, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow();
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    n_cmp += 5;
    if (err !== 1'b1) begin n_err++; $display("FAIL overflow err got %b want 1", err); end
    if (done !== 1'b0) begin n_err++; $display("FAIL overflow done got %b want 0", done); end
    if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL overflow cpu_rst got %b want 1", cpu_rst); end
    if (byte_ready !== 1'b0) begin n_err++; $display("FAIL overflow byte_ready got %b want 0", byte_ready); end
    if (word_count !== 16'h0401) begin n_err++; $display("FAIL overflow word_count got %h want 0401", word_count); end
    byte_valid = 1'b1; byte_data = 8'h55;
    repeat (8) begin @(posedge clk); #1; end
    byte_valid = 1'b0;
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL overflow writes got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_zero();
    pulse_start();
    n_cmp++;
    if (err !== 1'b0) begin n_err++; $display("FAIL zero err after start got %b want 0", err); end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    n_cmp += 2;
    if (done !== 1'b0) begin n_err++; $display("FAIL zero done before chk got %b want 0", done); end
    if (byte_ready !== 1'b1) begin n_err++; $display("FAIL zero byte_ready before chk got %b want 1", byte_ready); end
    send_byte(8'h00, 0);
`endif
    n_cmp += 4;
    if (done !== 1'b1) begin n_err++; $display("FAIL zero done got %b want 1", done); end
    if (cpu_rst !== 1'b0) begin n_err++; $display("FAIL zero cpu_rst got %b want 0", cpu_rst); end
    if (byte_ready !== 1'b0) begin n_err++; $display("FAIL zero byte_ready got %b want 0", byte_ready); end
    if (word_count !== 16'd0) begin n_err++; $display("FAIL zero word_count got %0d want 0", word_count); end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL zero writes got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_full_depth();
    pulse_start();
    frame_q.delete();
    for (int i = 0; i < (1 << AW); i++) frame_q.push_back($urandom);
    send_frame(0, 8'h00);
    wait_end("full");
    n_cmp += 2;
    if (done !== 1'b1) begin n_err++; $display("FAIL full done got %b want 1", done); end
    if (word_count !== 16'd1024) begin n_err++; $display("FAIL full word_count got %0d want 1024", word_count); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL full write count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL full write got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef IM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    frame_q = '{32'h20080005, 32'h00084820};
    for (int r = 0; r < 3; r++) begin
      pulse_start();
      send_frame(0, (r == 1) ? 8'hFF : 8'h00);
      wait_end("checksum");
      n_cmp += 3;
      if (done !== (r != 1)) begin n_err++; $display("FAIL checksum%0d done got %b want %b", r, done, r != 1); end
      if (err !== (r == 1)) begin n_err++; $display("FAIL checksum%0d err got %b want %b", r, err, r == 1); end
      if (cpu_rst !== (r == 1)) begin n_err++; $display("FAIL checksum%0d cpu_rst got %b want %b", r, cpu_rst, r == 1); end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL checksum%0d write count got %0d want %0d", r, obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        wr_t e, o;
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL checksum%0d write got %h:%h want %h:%h", r, o.addr, o.data, e.addr, e.data); end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start_with_byte();
    test_basic(0, "basic");
    test_basic(1, "stall");
    test_overflow();
    test_zero();
    test_full_depth();
`ifdef IM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
